// File: rtl/enemy_ai_ctrl.sv
// Enemy behaviour controller: an LFSR-driven Moore FSM that picks move,
// attack, defend or evade actions from player and bullet proximity.
module enemy_ai_ctrl #(
    parameter int          POS_WIDTH    = 11,
    parameter int          NEAR_DIST    = 64,
    parameter int          HOLD_TICKS   = 8,
    parameter int          ATK_COOLDOWN = 16,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_en,
    input  logic                        i_tick,
    input  logic signed [POS_WIDTH-1:0] i_player_x,
    input  logic signed [POS_WIDTH-1:0] i_enemy_x,
    input  logic signed [POS_WIDTH-1:0] i_goodbullet_x,
    input  logic                        i_goodbullet_isE,
    output logic                        o_right,
    output logic                        o_left,
    output logic                        o_jump,
    output logic                        o_squat,
    output logic                        o_attack,
    output logic                        o_defend,
    output logic [2:0]                  o_state
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] DECIDE = 3'd1;
    localparam logic [2:0] MOVE   = 3'd2;
    localparam logic [2:0] ATTACK = 3'd3;
    localparam logic [2:0] DEFEND = 3'd4;
    localparam logic [2:0] EVADE  = 3'd5;

    localparam int DW = POS_WIDTH + 1;
    localparam int NW = DW + 1;
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam int CW = (ATK_COOLDOWN > 0) ? $clog2(ATK_COOLDOWN + 1) : 1;

    localparam logic [15:0]   SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0]   POLY      = 16'hB400;
    localparam logic [NW-1:0] NEAR      = NW'(NEAR_DIST);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TICKS - 1);
    localparam logic [CW-1:0] CD_LOAD   = CW'(ATK_COOLDOWN);

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [HW-1:0] hold;
    logic [CW-1:0] atk_cd;
    logic [15:0]   lfsr;
    logic          dir_right;
    logic          dir_left;
    logic          evade_jump;

    logic signed [DW-1:0] dx;
    logic signed [DW-1:0] db;
    logic [DW-1:0]        abs_dx;
    logic [DW-1:0]        abs_db;
    logic                 bullet_near;
    logic                 player_near;
    logic                 holding;
    logic                 hold_done;

    // One extra bit keeps the full +/- span of the difference without wrap.
    assign dx = {i_player_x[POS_WIDTH-1], i_player_x}
              - {i_enemy_x[POS_WIDTH-1], i_enemy_x};
    assign db = {i_goodbullet_x[POS_WIDTH-1], i_goodbullet_x}
              - {i_enemy_x[POS_WIDTH-1], i_enemy_x};

    assign abs_dx = dx[DW-1] ? $unsigned(-dx) : $unsigned(dx);
    assign abs_db = db[DW-1] ? $unsigned(-db) : $unsigned(db);

    assign bullet_near = i_goodbullet_isE && ({1'b0, abs_db} < NEAR);
    assign player_near = ({1'b0, abs_dx} <= NEAR);

    assign holding   = (state == MOVE) || (state == DEFEND) || (state == EVADE);
    assign hold_done = i_tick && (hold == '0);

    always_comb begin
        state_nxt = state;
        if (!i_en) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: state_nxt = DECIDE;
                DECIDE: begin
                    if (bullet_near)
                        state_nxt = DEFEND;
                    else if (player_near && (atk_cd == '0))
                        state_nxt = ATTACK;
                    else if (lfsr[1:0] == 2'b00)
                        state_nxt = EVADE;
                    else
                        state_nxt = MOVE;
                end
                MOVE, DEFEND, EVADE: begin
                    if (hold_done)
                        state_nxt = DECIDE;
                end
                ATTACK: state_nxt = DECIDE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= SEED;
        end else if (i_tick) begin
            lfsr <= lfsr[0] ? ((lfsr >> 1) ^ POLY) : (lfsr >> 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold   <= '0;
            atk_cd <= '0;
        end else if (!i_en) begin
            hold   <= '0;
            atk_cd <= '0;
        end else begin
            if (state == DECIDE)
                hold <= HOLD_LOAD;
            else if (holding && i_tick && (hold != '0))
                hold <= hold - HW'(1);

            // The reload on the attack cycle wins over a coincident tick.
            if (state == ATTACK)
                atk_cd <= CD_LOAD;
            else if (i_tick && (atk_cd != '0))
                atk_cd <= atk_cd - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_right  <= 1'b0;
            dir_left   <= 1'b0;
            evade_jump <= 1'b0;
        end else if (state == DECIDE) begin
            if (state_nxt == MOVE) begin
                dir_right <= !dx[DW-1] && (dx != '0);
                dir_left  <= dx[DW-1];
            end
            if (state_nxt == EVADE)
                evade_jump <= lfsr[2];
        end
    end

    assign o_state  = state;
    assign o_right  = (state == MOVE) && dir_right;
    assign o_left   = (state == MOVE) && dir_left && !dir_right;
    assign o_jump   = (state == EVADE) && evade_jump;
    assign o_squat  = (state == EVADE) && !evade_jump;
    assign o_attack = (state == ATTACK);
    assign o_defend = (state == DEFEND);

endmodule

// File: tb/tb_enemy_ai_ctrl.sv
// Bench for enemy_ai_ctrl: vector table of first decisions with hold timing,
// plus cooldown, enable-drop, async-reset and zero-seed sequences.
module tb_enemy_ai_ctrl;

    typedef struct {
        int         pre;
        int         px;
        int         ex;
        int         bx;
        logic       be;
        logic [2:0] st;
        logic [5:0] cmd;
        logic       zchk;
        logic [2:0] zst;
        logic [5:0] zcmd;
    } vec_t;

    typedef struct {
        logic [2:0] st;
        logic [5:0] cmd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_en = 1'b0;
    logic i_tick = 1'b0;
    logic signed [10:0] player_x = '0;
    logic signed [10:0] enemy_x = '0;
    logic signed [10:0] bullet_x = '0;
    logic bullet_e = 1'b0;

    logic o_right, o_left, o_jump, o_squat, o_attack, o_defend;
    logic [2:0] o_state;
    logic z_right, z_left, z_jump, z_squat, z_attack, z_defend;
    logic [2:0] z_state;

    logic [5:0] cmd;
    logic [5:0] zcmd;
    assign cmd  = {o_right, o_left, o_jump, o_squat, o_attack, o_defend};
    assign zcmd = {z_right, z_left, z_jump, z_squat, z_attack, z_defend};

    int n_tests = 0;
    int n_fail = 0;
    exp_t q[$];
    vec_t v[16];

    enemy_ai_ctrl u_dut (
        .clk(clk), .rst(rst), .i_en(i_en), .i_tick(i_tick),
        .i_player_x(player_x), .i_enemy_x(enemy_x),
        .i_goodbullet_x(bullet_x), .i_goodbullet_isE(bullet_e),
        .o_right(o_right), .o_left(o_left), .o_jump(o_jump),
        .o_squat(o_squat), .o_attack(o_attack), .o_defend(o_defend),
        .o_state(o_state)
    );

    enemy_ai_ctrl #(.LFSR_SEED(16'h0000)) u_dut0 (
        .clk(clk), .rst(rst), .i_en(i_en), .i_tick(i_tick),
        .i_player_x(player_x), .i_enemy_x(enemy_x),
        .i_goodbullet_x(bullet_x), .i_goodbullet_isE(bullet_e),
        .o_right(z_right), .o_left(z_left), .o_jump(z_jump),
        .o_squat(z_squat), .o_attack(z_attack), .o_defend(z_defend),
        .o_state(z_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && ((o_right && o_left) || (o_jump && o_squat) ||
                     (o_attack && o_defend))) begin
            n_fail++;
            $display("FAIL exclusive outputs at %0t: cmd=%b", $time, cmd);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [8:0] got,
                       input logic [8:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got state=%0d cmd=%b, expected state=%0d cmd=%b",
                     name, got[8:6], got[5:0], exp[8:6], exp[5:0]);
        end
    endtask

    task automatic push(input logic [2:0] st, input logic [5:0] c);
        exp_t e;
        e.st = st;
        e.cmd = c;
        q.push_back(e);
    endtask

    task automatic sb(input string name);
        exp_t e;
        if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = q.pop_front();
            chk(name, {o_state, cmd}, {e.st, e.cmd});
        end
    endtask

    task automatic tick1();
        i_tick = 1'b1;
        step();
        i_tick = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_en = 1'b0;
        i_tick = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic set_pos(input int px, input int ex, input int bx,
                           input logic be);
        player_x = 11'(px);
        enemy_x = 11'(ex);
        bullet_x = 11'(bx);
        bullet_e = be;
    endtask

    task automatic run_vec(input vec_t t, input int idx);
        string nm;
        nm = $sformatf("vec%0d", idx);
        do_reset();
        set_pos(t.px, t.ex, t.bx, t.be);
        for (int k = 0; k < t.pre; k++) begin
            tick1();
            step();
        end
        push(3'd0, 6'b0);
        sb({nm, "_idle"});
        i_en = 1'b1;
        step();
        push(3'd1, 6'b0);
        sb({nm, "_decide"});
        step();
        push(t.st, t.cmd);
        sb({nm, "_action"});
        if (t.zchk)
            chk({nm, "_seed0"}, {z_state, zcmd}, {t.zst, t.zcmd});
        if (t.st == 3'd3) begin
            step();
            push(3'd1, 6'b0);
            sb({nm, "_after_attack"});
        end else begin
            for (int k = 1; k <= 8; k++) begin
                tick1();
                if (k < 8) begin
                    push(t.st, t.cmd);
                    sb($sformatf("%s_hold%0d", nm, k));
                    step();
                    push(t.st, t.cmd);
                    sb($sformatf("%s_gap%0d", nm, k));
                end else begin
                    push(3'd1, 6'b0);
                    sb({nm, "_hold_end"});
                end
            end
        end
    endtask

    initial begin
        int first_t;
        int second_t;
        int ticks;
        int n_att;

        v[0]  = '{0, 100, 10, 0, 1'b0, 3'd2, 6'b100000, 1'b1, 3'd2, 6'b100000};
        v[1]  = '{0, 10, 100, 0, 1'b0, 3'd2, 6'b010000, 1'b0, 3'd0, 6'b0};
        v[2]  = '{0, 50, 20, 0, 1'b0, 3'd3, 6'b000010, 1'b0, 3'd0, 6'b0};
        v[3]  = '{0, 50, 20, 60, 1'b1, 3'd4, 6'b000001, 1'b0, 3'd0, 6'b0};
        v[4]  = '{0, 50, 20, 60, 1'b0, 3'd3, 6'b000010, 1'b0, 3'd0, 6'b0};
        v[5]  = '{0, 1023, -1024, 0, 1'b0, 3'd2, 6'b100000, 1'b0, 3'd0, 6'b0};
        v[6]  = '{0, -1024, 1023, 0, 1'b0, 3'd2, 6'b010000, 1'b0, 3'd0, 6'b0};
        v[7]  = '{1, 500, 0, 0, 1'b0, 3'd5, 6'b000100, 1'b1, 3'd5, 6'b000100};
        v[8]  = '{3, 500, 0, 0, 1'b0, 3'd5, 6'b001000, 1'b0, 3'd0, 6'b0};
        v[9]  = '{4, 500, 0, 0, 1'b0, 3'd2, 6'b100000, 1'b0, 3'd0, 6'b0};
        v[10] = '{0, 74, 10, 0, 1'b0, 3'd3, 6'b000010, 1'b0, 3'd0, 6'b0};
        v[11] = '{0, 75, 10, 0, 1'b0, 3'd2, 6'b100000, 1'b0, 3'd0, 6'b0};
        v[12] = '{0, 500, 10, 74, 1'b1, 3'd2, 6'b100000, 1'b0, 3'd0, 6'b0};
        v[13] = '{0, 500, 10, 73, 1'b1, 3'd4, 6'b000001, 1'b0, 3'd0, 6'b0};
        v[14] = '{0, 50, 100, 60, 1'b1, 3'd4, 6'b000001, 1'b0, 3'd0, 6'b0};
        v[15] = '{1, 50, 20, 0, 1'b0, 3'd3, 6'b000010, 1'b0, 3'd0, 6'b0};

        #1;
        push(3'd0, 6'b0);
        sb("reset_state");

        for (int i = 0; i < 16; i++)
            run_vec(v[i], i);

        // Cooldown between attacks while the player stays in range.
        do_reset();
        set_pos(50, 20, 0, 1'b0);
        i_en = 1'b1;
        ticks = 0;
        n_att = 0;
        first_t = 0;
        second_t = 0;
        for (int c = 0; c < 300 && n_att < 2; c++) begin
            i_tick = (c % 3 == 2);
            step();
            if (i_tick)
                ticks++;
            i_tick = 1'b0;
            if (o_attack) begin
                if (n_att == 0)
                    first_t = ticks;
                else
                    second_t = ticks;
                n_att++;
            end
        end
        n_tests++;
        if (n_att < 2) begin
            n_fail++;
            $display("FAIL cooldown_timeout: got %0d attacks, expected 2", n_att);
        end else begin
            n_tests++;
            if ((second_t - first_t) < 16 || (second_t - first_t) > 26) begin
                n_fail++;
                $display("FAIL cooldown_gap: got %0d ticks, expected 16..26",
                         second_t - first_t);
            end
        end

        // Enable drop mid-move, then re-enable with the cooldown cleared.
        do_reset();
        set_pos(50, 20, 0, 1'b0);
        i_en = 1'b1;
        step();
        step();
        push(3'd3, 6'b000010);
        sb("endrop_attack");
        step();
        step();
        push(3'd2, 6'b100000);
        sb("endrop_move");
        tick1();
        tick1();
        i_en = 1'b0;
        i_tick = 1'b1;
        step();
        i_tick = 1'b0;
        push(3'd0, 6'b0);
        sb("endrop_idle");
        i_en = 1'b1;
        step();
        push(3'd1, 6'b0);
        sb("reen_decide");
        step();
        push(3'd3, 6'b000010);
        sb("reen_attack");

        // Zero horizontal distance while cooling down: move with no direction.
        do_reset();
        set_pos(300, 300, 0, 1'b0);
        i_en = 1'b1;
        step();
        step();
        step();
        step();
        push(3'd2, 6'b000000);
        sb("dx_zero_move");

        // Asynchronous reset in the middle of a defend action.
        do_reset();
        set_pos(50, 20, 60, 1'b1);
        i_en = 1'b1;
        step();
        step();
        push(3'd4, 6'b000001);
        sb("defend_before_rst");
        #2;
        rst = 1'b1;
        #1;
        push(3'd0, 6'b0);
        sb("async_rst");
        chk("async_rst_seed0", {z_state, zcmd}, 9'd0);
        step();
        rst = 1'b0;
        i_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/enemy_ai_ctrl.md
ENEMY_AI_CTRL -- requirements
Module: enemy_ai_ctrl

Interface
REQ-001 Parameter POS_WIDTH, default 11, width of signed position inputs.
REQ-002 Parameter NEAR_DIST, default 64, attack/threat radius in pixels.
REQ-003 Parameter HOLD_TICKS, default 8, action hold duration in i_tick strobes (>=1).
REQ-004 Parameter ATK_COOLDOWN, default 16, ticks between attacks.
REQ-005 Parameter LFSR_SEED, default 16'hACE1, initial LFSR value.
REQ-006 clk  in  1  system clock; all state changes on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 i_en  in  1  high while game is in PLAY state.
REQ-009 i_tick  in  1  one-cycle frame strobe.
REQ-010 i_player_x, i_enemy_x  in  POS_WIDTH signed  horizontal positions.
REQ-011 i_goodbullet_x  in  POS_WIDTH signed  player bullet x; i_goodbullet_isE  in  1  player bullet exists.
REQ-012 o_right, o_left, o_jump, o_squat, o_attack, o_defend  out  1 each  enemy command strobes/levels.
REQ-013 o_state  out  3  current FSM state: IDLE=0, DECIDE=1, MOVE=2, ATTACK=3, DEFEND=4, EVADE=5.

Function
REQ-014 All outputs SHALL be registered and a pure function of the registered state plus the latched direction/evade-type bits (Moore).
REQ-015 16-bit Galois LFSR, polynomial mask 16'hB400, SHALL advance once per i_tick regardless of i_en; seed 0 SHALL be replaced by 16'h0001.
REQ-016 dx = i_player_x - i_enemy_x and db = i_goodbullet_x - i_enemy_x SHALL be computed at POS_WIDTH+1 bits signed; |dx|, |db| without overflow.
REQ-017 IDLE: all command outputs 0; i_en=1 -> DECIDE next cycle.
REQ-018 DECIDE lasts exactly one cycle; next state by priority: (a) i_goodbullet_isE and |db|<NEAR_DIST -> DEFEND; (b) |dx|<=NEAR_DIST and atk_cd==0 -> ATTACK; (c) lfsr[1:0]==2'b00 -> EVADE; (d) else MOVE.
REQ-019 On MOVE entry, direction SHALL latch: dx>0 right, dx<0 left, dx==0 none; o_right/o_left SHALL never both be 1.
REQ-020 On EVADE entry, lfsr[2]=1 latches jump, else squat; o_jump/o_squat held while in EVADE, never both 1.
REQ-021 MOVE, DEFEND, EVADE SHALL load hold counter with HOLD_TICKS-1 on entry, decrement on i_tick, and return to DECIDE on the cycle after an i_tick seen with counter==0.
REQ-022 ATTACK lasts exactly one cycle with o_attack=1, loads atk_cd=ATK_COOLDOWN, then DECIDE.
REQ-023 atk_cd SHALL decrement on each i_tick, saturating at 0.
REQ-024 o_attack and o_defend SHALL never be 1 in the same cycle.
REQ-025 i_en=0 in any state SHALL force IDLE next cycle, clear hold counter and atk_cd; i_en has priority over tick-driven exits.
REQ-026 Latency: i_en rising at edge N -> DECIDE at N+1 -> first command output at N+2.

Reset
REQ-027 rst=1 SHALL immediately set state IDLE, all command outputs 0, o_state=0, hold counter 0, atk_cd 0, LFSR to (corrected) LFSR_SEED.
REQ-028 Deassertion of rst SHALL take effect at the next clk edge; reset mid-action SHALL abandon the action with no residual output.

Verification
REQ-029 rst, i_en=1, player_x=100, enemy_x=10, no bullet, LFSR seed yielding lfsr[1:0]!=0 -> o_state 0,1,2; o_right=1 for exactly 8 ticks, o_left=0.
REQ-030 player_x=50, enemy_x=20 (|dx|=30) -> one-cycle o_attack; next ATTACK not before 16 ticks elapse.
REQ-031 bullet isE=1, goodbullet_x=enemy_x+40, enemy in attack range -> DEFEND chosen over ATTACK; o_defend high 8 ticks, o_attack 0 throughout.
REQ-032 i_en dropped mid-MOVE -> next cycle o_state=0, all outputs 0; re-enable -> DECIDE, atk_cd=0.
REQ-033 Extreme positions player_x=+1023, enemy_x=-1024 -> dx correct (2047), o_right=1, no wrap to left.
REQ-034 rst asserted mid-DEFEND without clock -> outputs 0 immediately; LFSR_SEED=0 -> LFSR starts at 16'h0001, never locks at 0.
